// File: rtl/pdu_pkg.sv
// Shared types and constants for the PDU run controller: FSM states,
// halt-cause encodings and the slot-index width helper.
package pdu_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [1:0] HC_RESET = 2'd0;
    localparam logic [1:0] HC_STEP  = 2'd1;
    localparam logic [1:0] HC_BRK   = 2'd2;
    localparam logic [1:0] HC_HALT  = 2'd3;

    // A single slot still needs a one-bit index port.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pdu_run_ctrl_if.sv
// Debug-path bus between the PDU front end / CPU debug port (master) and
// the run controller (slave).
interface pdu_run_ctrl_if
    import pdu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int NUM_BRK = 4,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = idx_width(NUM_BRK)
) ();

    logic              step_p;
    logic              cont_p;
    logic              halt_p;
    logic [STEP_W-1:0] step_n;
    logic              brk_we;
    logic [IDX_W-1:0]  brk_idx;
    logic [PC_W-1:0]   brk_addr;
    logic              brk_en;
    logic [PC_W-1:0]   chk_pc;
    logic              cnt_clr;
    logic              cpu_en;
    logic              run;
    logic [1:0]        halt_cause;
    logic [IDX_W-1:0]  brk_hit_idx;
    logic [CNT_W-1:0]  cyc_cnt;

    modport master (
        output step_p, cont_p, halt_p, step_n, brk_we, brk_idx, brk_addr,
               brk_en, chk_pc, cnt_clr,
        input  cpu_en, run, halt_cause, brk_hit_idx, cyc_cnt
    );

    modport slave (
        input  step_p, cont_p, halt_p, step_n, brk_we, brk_idx, brk_addr,
               brk_en, chk_pc, cnt_clr,
        output cpu_en, run, halt_cause, brk_hit_idx, cyc_cnt
    );

endinterface

// File: rtl/pdu_brk_match.sv
// Breakpoint slot register file with one comparator per slot; reports any
// match against chk_pc and the lowest matching slot index, combinationally.
module pdu_brk_match #(
    parameter int PC_W    = 32,
    parameter int NUM_BRK = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PC_W-1:0]  wr_addr,
    input  logic             wr_slot_en,
    input  logic [PC_W-1:0]  chk_pc,
    output logic             any_hit,
    output logic [IDX_W-1:0] hit_idx
);

    logic [PC_W-1:0]    addr_q [NUM_BRK];
    logic [PC_W-1:0]    addr_d [NUM_BRK];
    logic [NUM_BRK-1:0] en_q;
    logic [NUM_BRK-1:0] en_d;
    logic [NUM_BRK-1:0] match_s;
    logic [IDX_W-1:0]   hit_idx_s;

    // Slot write decode; out-of-range indices match no slot.
    always_comb begin
        en_d = en_q;
        for (int i = 0; i < NUM_BRK; i++) begin
            addr_d[i] = addr_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                addr_d[i] = wr_addr;
                en_d[i]   = wr_slot_en;
            end else begin
                addr_d[i] = addr_q[i];
            end
        end
    end

    // Comparators and lowest-index priority encode (scan high to low).
    always_comb begin
        hit_idx_s = '0;
        for (int i = 0; i < NUM_BRK; i++) begin
            match_s[i] = en_q[i] && (addr_q[i] == chk_pc);
        end
        for (int i = NUM_BRK - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            for (int i = 0; i < NUM_BRK; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            en_q <= en_d;
            for (int i = 0; i < NUM_BRK; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign any_hit = |match_s;
    assign hit_idx = hit_idx_s;

endmodule

// File: rtl/pdu_run_ctrl.sv
// CPU run controller: STOP/STEP/RUN FSM driving a CPU clock enable, with
// multi-instruction stepping, breakpoints, manual halt and a cycle counter.
module pdu_run_ctrl
    import pdu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int NUM_BRK = 4,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = idx_width(NUM_BRK)
) (
    input  logic         clk,
    input  logic         rst,
    pdu_run_ctrl_if.slave bus
);

    state_e            state_q,    state_d;
    logic [STEP_W-1:0] step_rem_q, step_rem_d;
    logic              skip_q,     skip_d;
    logic [1:0]        cause_q,    cause_d;
    logic [IDX_W-1:0]  hit_idx_q,  hit_idx_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              brk_wr_s;
    logic              any_hit_s;
    logic [IDX_W-1:0]  match_idx_s;
    logic              hit_s;
    logic              cpu_en_s;

    assign brk_wr_s = bus.brk_we && (state_q == ST_STOP);

    pdu_brk_match #(
        .PC_W    (PC_W),
        .NUM_BRK (NUM_BRK),
        .IDX_W   (IDX_W)
    ) u_brk_match (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (brk_wr_s),
        .wr_idx     (bus.brk_idx),
        .wr_addr    (bus.brk_addr),
        .wr_slot_en (bus.brk_en),
        .chk_pc     (bus.chk_pc),
        .any_hit    (any_hit_s),
        .hit_idx    (match_idx_s)
    );

    // The match gates cpu_en in the same cycle so the breakpoint
    // instruction never executes; skip lets a resume step past it.
    assign hit_s    = (state_q == ST_RUN) && any_hit_s && !skip_q;
    assign cpu_en_s = !bus.halt_p &&
                      ((state_q == ST_STEP) || ((state_q == ST_RUN) && !hit_s));

    // Next-state, step count, skip flag and stop-reason logic.
    always_comb begin
        state_d    = state_q;
        step_rem_d = step_rem_q;
        skip_d     = skip_q;
        cause_d    = cause_q;
        hit_idx_d  = hit_idx_q;
        case (state_q)
            ST_STOP: begin
                if (bus.step_p) begin
                    state_d    = ST_STEP;
                    step_rem_d = (bus.step_n == '0) ? STEP_W'(1) : bus.step_n;
                end else if (bus.cont_p) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_STEP: begin
                if (bus.halt_p) begin
                    state_d = ST_STOP;
                    cause_d = HC_HALT;
                end else begin
                    step_rem_d = step_rem_q - STEP_W'(1);
                    if (step_rem_q == STEP_W'(1)) begin
                        state_d = ST_STOP;
                        cause_d = HC_STEP;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (bus.halt_p) begin
                    state_d = ST_STOP;
                    cause_d = HC_HALT;
                end else if (hit_s) begin
                    state_d   = ST_STOP;
                    cause_d   = HC_BRK;
                    hit_idx_d = match_idx_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // Enabled-cycle counter; clear wins over increment.
    always_comb begin
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (cpu_en_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_STOP;
            step_rem_q <= '0;
            skip_q     <= 1'b0;
            cause_q    <= HC_RESET;
            hit_idx_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_rem_q <= step_rem_d;
            skip_q     <= skip_d;
            cause_q    <= cause_d;
            hit_idx_q  <= hit_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.cpu_en      = cpu_en_s;
    assign bus.run         = (state_q != ST_STOP);
    assign bus.halt_cause  = cause_q;
    assign bus.brk_hit_idx = hit_idx_q;
    assign bus.cyc_cnt     = cnt_q;

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// Directed self-checking bench for pdu_run_ctrl (CNT_W=4 to exercise wrap);
// the bench models the CPU PC, advancing by 4 on each enabled cycle.
module tb_pdu_run_ctrl;

    localparam int PC_W    = 32;
    localparam int NUM_BRK = 4;
    localparam int STEP_W  = 8;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [PC_W-1:0] pc;

    pdu_run_ctrl_if #(.PC_W(PC_W), .NUM_BRK(NUM_BRK), .STEP_W(STEP_W),
                      .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    pdu_run_ctrl #(.PC_W(PC_W), .NUM_BRK(NUM_BRK), .STEP_W(STEP_W),
                   .CNT_W(CNT_W), .IDX_W(IDX_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_slot(input logic [IDX_W-1:0] idx, input logic [PC_W-1:0] addr,
                           input logic en);
        bus.brk_we = 1'b1; bus.brk_idx = idx; bus.brk_addr = addr; bus.brk_en = en;
        tick();
        bus.brk_we = 1'b0;
    endtask

    task automatic clr_cnt();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
    endtask

    task automatic pulse_step(input logic [STEP_W-1:0] n);
        bus.step_n = n; bus.step_p = 1'b1;
        tick();
        bus.step_p = 1'b0;
    endtask

    task automatic pulse_cont();
        bus.chk_pc = pc; bus.cont_p = 1'b1;
        tick();
        bus.cont_p = 1'b0;
    endtask

    // Runs the CPU model until run falls or max_cyc cycles elapse.
    task automatic run_loop(input int max_cyc, input bit wr_mid, output int n_en,
                            output bit first_en, output bit last_en, output bit stopped);
        logic en;
        n_en = 0; stopped = 1'b0; first_en = 1'b0; last_en = 1'b0;
        for (int c = 0; c < max_cyc && !stopped; c++) begin
            bus.chk_pc = pc;
            if (wr_mid && c == 2) begin
                bus.brk_we = 1'b1; bus.brk_idx = 2'd0;
                bus.brk_addr = 32'h0000_0060; bus.brk_en = 1'b1;
            end
            #2;
            en = bus.cpu_en;
            if (c == 0) first_en = en;
            last_en = en;
            tick();
            bus.brk_we = 1'b0;
            if (en) begin
                pc = pc + 32'd4;
                n_en++;
            end
            if (!bus.run) stopped = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (bus.cpu_en !== 1'b0 || bus.run !== 1'b0 || bus.halt_cause !== 2'd0 ||
            bus.brk_hit_idx !== 2'd0 || bus.cyc_cnt !== 4'd0) begin
            $display("FAIL reset_values: got cpu_en=%b run=%b cause=%0d idx=%0d cnt=%0d, want 0 0 0 0 0",
                     bus.cpu_en, bus.run, bus.halt_cause, bus.brk_hit_idx, bus.cyc_cnt);
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_step_zero();
        int n; bit f, l, s;
        pulse_step(8'd0);
        run_loop(20, 1'b0, n, f, l, s);
        checks++;
        if (n !== 1 || !s) begin
            $display("FAIL step_zero_len: got %0d enabled cycles (stopped=%b), want 1", n, s);
            errors++;
        end
        checks++;
        if (bus.halt_cause !== 2'd1 || bus.cyc_cnt !== 4'd1) begin
            $display("FAIL step_zero_status: got cause=%0d cnt=%0d, want 1 1",
                     bus.halt_cause, bus.cyc_cnt);
            errors++;
        end
    endtask

    task automatic test_step_five();
        int n; bit f, l, s;
        clr_cnt();
        pulse_step(8'd5);
        run_loop(20, 1'b0, n, f, l, s);
        checks++;
        if (n !== 5 || !s || !f) begin
            $display("FAIL step_five_len: got %0d enabled cycles (first=%b stopped=%b), want 5",
                     n, f, s);
            errors++;
        end
        checks++;
        if (bus.run !== 1'b0 || bus.halt_cause !== 2'd1 || bus.cyc_cnt !== 4'd5) begin
            $display("FAIL step_five_status: got run=%b cause=%0d cnt=%0d, want 0 1 5",
                     bus.run, bus.halt_cause, bus.cyc_cnt);
            errors++;
        end
    endtask

    task automatic test_priority();
        int n; bit f, l, s;
        bus.step_n = 8'd2; bus.step_p = 1'b1; bus.cont_p = 1'b1;
        tick();
        bus.step_p = 1'b0; bus.cont_p = 1'b0;
        run_loop(20, 1'b0, n, f, l, s);
        checks++;
        if (n !== 2 || !s || bus.halt_cause !== 2'd1) begin
            $display("FAIL step_over_cont: got %0d cycles cause=%0d, want 2 cycles cause 1",
                     n, bus.halt_cause);
            errors++;
        end
    endtask

    task automatic test_breakpoint();
        int n; bit f, l, s;
        wr_slot(2'd2, 32'h0000_0040, 1'b1);
        pc = 32'd0;
        clr_cnt();
        pulse_cont();
        run_loop(100, 1'b0, n, f, l, s);
        checks++;
        if (!s || l !== 1'b0 || pc !== 32'h40 || n !== 16) begin
            $display("FAIL brk_stop: got stopped=%b last_en=%b pc=%h cycles=%0d, want 1 0 40 16",
                     s, l, pc, n);
            errors++;
        end
        checks++;
        if (bus.halt_cause !== 2'd2 || bus.brk_hit_idx !== 2'd2 || bus.cyc_cnt !== 4'd0) begin
            $display("FAIL brk_status: got cause=%0d idx=%0d cnt=%0d, want 2 2 0",
                     bus.halt_cause, bus.brk_hit_idx, bus.cyc_cnt);
            errors++;
        end
    endtask

    task automatic test_resume_multi();
        int n; bit f, l, s;
        wr_slot(2'd1, 32'h0000_0080, 1'b1);
        wr_slot(2'd3, 32'h0000_0080, 1'b1);
        pulse_cont();
        run_loop(100, 1'b1, n, f, l, s);
        checks++;
        if (f !== 1'b1) begin
            $display("FAIL resume_first_en: got cpu_en=%b at pc 40, want 1", f);
            errors++;
        end
        checks++;
        if (!s || pc !== 32'h80 || n !== 16) begin
            $display("FAIL multi_stop: got stopped=%b pc=%h cycles=%0d, want 1 80 16", s, pc, n);
            errors++;
        end
        checks++;
        if (bus.halt_cause !== 2'd2 || bus.brk_hit_idx !== 2'd1) begin
            $display("FAIL multi_idx: got cause=%0d idx=%0d, want 2 1",
                     bus.halt_cause, bus.brk_hit_idx);
            errors++;
        end
    endtask

    task automatic test_halt_hit();
        int bad;
        wr_slot(2'd0, 32'h0000_0028, 1'b1);
        pc = 32'd0;
        clr_cnt();
        pulse_cont();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            bus.chk_pc = pc;
            #2;
            if (bus.cpu_en !== 1'b1) bad++;
            tick();
            pc = pc + 32'd4;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL halt_run_en: got %0d disabled cycles before halt, want 0", bad);
            errors++;
        end
        bus.chk_pc = pc;
        bus.halt_p = 1'b1;
        #2;
        checks++;
        if (bus.cpu_en !== 1'b0) begin
            $display("FAIL halt_cpu_en: got %b, want 0", bus.cpu_en);
            errors++;
        end
        tick();
        bus.halt_p = 1'b0;
        checks++;
        if (bus.run !== 1'b0 || bus.halt_cause !== 2'd3 || bus.cyc_cnt !== 4'd10 ||
            bus.brk_hit_idx !== 2'd1) begin
            $display("FAIL halt_status: got run=%b cause=%0d cnt=%0d idx=%0d, want 0 3 10 1",
                     bus.run, bus.halt_cause, bus.cyc_cnt, bus.brk_hit_idx);
            errors++;
        end
    endtask

    task automatic test_wrap_clear();
        int n; bit f, l, s;
        clr_cnt();
        pulse_step(8'd17);
        run_loop(40, 1'b0, n, f, l, s);
        checks++;
        if (n !== 17 || bus.cyc_cnt !== 4'd1) begin
            $display("FAIL cnt_wrap: got cycles=%0d cnt=%0d, want 17 1", n, bus.cyc_cnt);
            errors++;
        end
        pulse_step(8'd3);
        tick(); tick();
        bus.cnt_clr = 1'b1;
        #2;
        checks++;
        if (bus.cpu_en !== 1'b1) begin
            $display("FAIL clr_cpu_en: got %b, want 1", bus.cpu_en);
            errors++;
        end
        tick();
        bus.cnt_clr = 1'b0;
        checks++;
        if (bus.cyc_cnt !== 4'd0 || bus.run !== 1'b0 || bus.halt_cause !== 2'd1) begin
            $display("FAIL clr_wins: got cnt=%0d run=%b cause=%0d, want 0 0 1",
                     bus.cyc_cnt, bus.run, bus.halt_cause);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        int n; bit f, l, s;
        pc = 32'd0;
        pulse_cont();
        run_loop(3, 1'b0, n, f, l, s);
        bus.chk_pc = pc;
        #2;
        checks++;
        if (bus.cpu_en !== 1'b1 || bus.run !== 1'b1) begin
            $display("FAIL pre_rst_run: got cpu_en=%b run=%b, want 1 1", bus.cpu_en, bus.run);
            errors++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.cpu_en !== 1'b0 || bus.run !== 1'b0 || bus.halt_cause !== 2'd0 ||
            bus.brk_hit_idx !== 2'd0 || bus.cyc_cnt !== 4'd0) begin
            $display("FAIL async_rst: got cpu_en=%b run=%b cause=%0d idx=%0d cnt=%0d, want 0 0 0 0 0",
                     bus.cpu_en, bus.run, bus.halt_cause, bus.brk_hit_idx, bus.cyc_cnt);
            errors++;
        end
        tick();
        rst = 1'b0;
        pc = 32'd0;
        pulse_cont();
        run_loop(20, 1'b0, n, f, l, s);
        checks++;
        if (s || n !== 20) begin
            $display("FAIL slots_cleared: got stopped=%b cycles=%0d pc=%h, want 0 20", s, n, pc);
            errors++;
        end
        bus.halt_p = 1'b1;
        tick();
        bus.halt_p = 1'b0;
        checks++;
        if (bus.run !== 1'b0 || bus.halt_cause !== 2'd3) begin
            $display("FAIL post_rst_halt: got run=%b cause=%0d, want 0 3", bus.run, bus.halt_cause);
            errors++;
        end
    endtask

    initial begin
        checks = 0; errors = 0; pc = '0;
        rst = 1'b1;
        bus.step_p = 1'b0; bus.cont_p = 1'b0; bus.halt_p = 1'b0; bus.step_n = '0;
        bus.brk_we = 1'b0; bus.brk_idx = '0; bus.brk_addr = '0; bus.brk_en = 1'b0;
        bus.chk_pc = '0; bus.cnt_clr = 1'b0;
        test_reset();
        test_step_zero();
        test_step_five();
        test_priority();
        test_breakpoint();
        test_resume_multi();
        test_halt_hit();
        test_wrap_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdu_run_ctrl.md
# pdu_run_ctrl

Parametrised CPU run controller for the PDU debug path. It replaces the single-breakpoint stop/step/run logic with NUM_BRK breakpoint slots, multi-instruction stepping, manual halt and resume-past-breakpoint. It drives a CPU clock enable rather than a gated clock, and it reports why the CPU stopped. It sits between the PDU button/switch front end, which supplies debounced single-cycle pulses, and the CPU debug bus, which supplies chk_pc.

## Interface
Parameters:
- PC_W, 32, width of chk_pc and breakpoint addresses
- NUM_BRK, 4, number of breakpoint slots (≥1)
- STEP_W, 8, width of step count
- CNT_W, 32, width of cycle counter
- IDX_W, $clog2(NUM_BRK) (min 1), slot index width

Ports:
- clk  in  1  PDU clock; one clock domain. All logic is posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- step_p  in  1  step request, single-cycle pulse.
- cont_p  in  1  run request, single-cycle pulse.
- halt_p  in  1  manual halt, single-cycle pulse.
- step_n  in  STEP_W  instructions per step; 0 is treated as 1.
- brk_we  in  1  breakpoint slot write strobe.
- brk_idx  in  IDX_W  slot written.
- brk_addr  in  PC_W  address for slot.
- brk_en  in  1  enable bit for slot.
- chk_pc  in  PC_W  PC the CPU executes on its next enabled edge.
- cnt_clr  in  1  clear cycle counter.
- cpu_en  out  1  CPU clock enable.
- run  out  1  high in STEP or RUN.
- halt_cause  out  2  0 reset, 1 step done, 2 breakpoint, 3 manual halt.
- brk_hit_idx  out  IDX_W  slot that caused the last breakpoint stop.
- cyc_cnt  out  CNT_W  count of cpu_en-high cycles.

## Operation
- State machine with states STOP, STEP and RUN. Reset state is STOP.
- STOP:
  - If step_p, go to STEP and load step_rem = (step_n==0 ? 1 : step_n).
  - Else if cont_p, go to RUN and set skip=1.
  - step_p takes priority over cont_p.
  - halt_p has no effect in STOP.
- STEP:
  - cpu_en=1 each cycle and step_rem decrements.
  - When step_rem==1 in a cycle with cpu_en=1, go to STOP with cause 1.
  - Exactly max(step_n,1) enabled cycles occur.
  - Breakpoints are not checked in STEP.
- RUN:
  - hit = OR over enabled slots of (slot_addr == chk_pc) && !skip.
  - If hit, cpu_en=0 that cycle (the breakpoint instruction does not execute), go to STOP, set cause 2, and latch brk_hit_idx = lowest matching index.
  - skip clears after the first RUN cycle. Resuming from a breakpoint therefore executes that instruction.
- halt_p in STEP or RUN:
  - Forces cpu_en=0 that cycle and goes to STOP with cause 3.
  - Priority over hit and over step completion.
- cpu_en is combinational from the registered state plus halt_p/hit: (STEP & ~halt_p) | (RUN & ~halt_p & ~hit).
- run = (state != STOP).
- Breakpoint writes:
  - Accepted only in STOP. brk_we in STEP or RUN is ignored.
  - A write in the same cycle as step_p or cont_p takes effect; the new slot is live from the first RUN cycle.
- cyc_cnt:
  - Increments on each cycle with cpu_en=1 and wraps at 2^CNT_W.
  - cnt_clr clears it; clear wins over increment.
- Reset values:
  - state STOP, cpu_en 0, run 0, halt_cause 0, brk_hit_idx 0, cyc_cnt 0.
  - All slots disabled with address 0; step_rem 0; skip 0.
- Reset mid-STEP or mid-RUN: immediate STOP, cpu_en drops asynchronously, and slots are cleared.

## Timing
- Pulse in STOP at edge k gives state STEP/RUN after edge k. The first cpu_en=1 is in cycle k+1.
- STEP with step_n=N: cpu_en high for cycles k+1..k+N; run falls after edge k+N.
- A breakpoint match is evaluated on the same-cycle chk_pc, with zero latency to cpu_en.
- halt_cause and brk_hit_idx update on the edge entering STOP and hold until the next stop.
- brk_hit_idx holds its old value on non-breakpoint stops.

## Structure
- Package pdu_pkg holds:
  - the state enum (STOP, STEP, RUN);
  - halt-cause constants (HC_RESET, HC_STEP, HC_BRK, HC_HALT).
- Sub-module pdu_brk_match holds the slot register file and the NUM_BRK comparators. It outputs any_hit and the lowest-index priority encode.
- The FSM, step counter, skip flag and cycle counter live in the top module.

## Test plan
- Reset, then step_p with step_n=0 -> exactly 1 cpu_en cycle; halt_cause=1; cyc_cnt=1.
- step_n=5, step_p -> 5 consecutive cpu_en cycles; run falls; cyc_cnt=5.
- Slot 2=0x0000_0040 enabled; cont_p; chk_pc ramps by 4 from 0 -> cpu_en=0 at chk_pc=0x40; halt_cause=2; brk_hit_idx=2. A second cont_p with chk_pc=0x40 -> cpu_en=1 on the first cycle and RUN continues.
- Slots 1 and 3 both =0x80 -> stop at 0x80 with brk_hit_idx=1. brk_we to slot 0 during RUN -> slot 0 remains disabled.
- cont_p, then halt_p 10 cycles later in the same cycle as a hit -> cpu_en=0; halt_cause=3; cyc_cnt=10.
- cyc_cnt preset near wrap (CNT_W=4): 17 enabled cycles -> cyc_cnt=1. cnt_clr coincident with cpu_en=1 -> cyc_cnt=0. Async rst mid-RUN -> cpu_en=0 immediately and all outputs at reset values.
